// File: rtl/lfsr_key_scheduler.sv
// lfsr_key_scheduler: two-channel round-robin key-word generator driven by a 16-bit LFSR
module lfsr_key_scheduler #(
  parameter int          STEPS = 16,
  parameter logic [15:0] SEED  = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [15:0] seed_value,
  input  logic [1:0]  req,
  output logic [1:0]  ack,
  output logic [15:0] key_out,
  output logic        busy,
  output logic [15:0] lfsr_state
);
  typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;
  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        g, rr, grant;
  logic [15:0] lfsr_next;
  always_comb begin
    lfsr_next  = {lfsr_state[14:0], lfsr_state[15] ^ lfsr_state[13]};
    grant      = req[rr] ? rr : !rr;
    state_next = state == IDLE ? ((!seed_load && |req) ? STEP : IDLE) :
                 state == STEP ? (cnt == 8'd0 ? DELIVER : STEP) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr_state <= SEED == 16'h0000 ? 16'h0001 : SEED;
      key_out    <= 16'h0000;
      ack        <= 2'b00;
      rr         <= 1'b0;
      g          <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      state <= state_next;
      ack   <= 2'b00;
      // an all-zero seed would lock the LFSR, so it is forced to one
      if (state == IDLE && seed_load) lfsr_state <= seed_value == 16'h0000 ? 16'h0001 : seed_value;
      if (state == IDLE && !seed_load && |req) begin
        g   <= grant;
        cnt <= 8'(STEPS - 1);
      end
      if (state == STEP) begin
        lfsr_state <= lfsr_next;
        cnt        <= cnt == 8'd0 ? cnt : cnt - 8'd1;
        if (cnt == 8'd0) begin
          key_out <= lfsr_next;
          ack     <= g ? 2'b10 : 2'b01;
          rr      <= !g;
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_key_scheduler.sv
// tb_lfsr_key_scheduler: directed and random checks of two scheduler instances against a transaction model
module tb_lfsr_key_scheduler;
  logic        clk = 1'b0;
  logic [1:0]  reset_i = 2'b11;
  logic [1:0]  seed_load_i = 2'b00;
  logic [15:0] seed_value_i [2] = '{16'h0, 16'h0};
  logic [1:0]  req_i [2] = '{2'b00, 2'b00};
  logic [1:0]  ack_o [2];
  logic [15:0] key_o [2];
  logic [15:0] lfsr_o [2];
  logic [1:0]  busy_o;
  int checks = 0;
  int failures = 0;
  int steps [2] = '{16, 1};
  bit          m_busy [2];
  int          m_t [2];
  logic [15:0] m_lfsr [2], m_base [2], m_key [2];
  logic [1:0]  m_ack [2];
  bit          m_rr [2], m_g [2];
  always #5 clk = ~clk;
  lfsr_key_scheduler u_dut (
    .clk(clk), .reset(reset_i[0]), .seed_load(seed_load_i[0]), .seed_value(seed_value_i[0]),
    .req(req_i[0]), .ack(ack_o[0]), .key_out(key_o[0]), .busy(busy_o[0]), .lfsr_state(lfsr_o[0])
  );
  lfsr_key_scheduler #(.STEPS(1), .SEED(16'h0000)) u_dut1 (
    .clk(clk), .reset(reset_i[1]), .seed_load(seed_load_i[1]), .seed_value(seed_value_i[1]),
    .req(req_i[1]), .ack(ack_o[1]), .key_out(key_o[1]), .busy(busy_o[1]), .lfsr_state(lfsr_o[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13]};
    return s;
  endfunction
  task automatic model(input int i);
    if (reset_i[i]) begin
      m_busy[i] = 0; m_lfsr[i] = 16'h0001; m_key[i] = 16'h0; m_ack[i] = 2'b00; m_rr[i] = 0;
    end else if (!m_busy[i]) begin
      if (seed_load_i[i]) m_lfsr[i] = seed_value_i[i] == 16'h0 ? 16'h0001 : seed_value_i[i];
      else if (req_i[i] != 2'b00) begin
        m_g[i] = req_i[i] == 2'b11 ? m_rr[i] : req_i[i][1];
        m_busy[i] = 1; m_t[i] = 0; m_base[i] = m_lfsr[i];
      end
    end else begin
      m_t[i]++;
      if (m_t[i] == steps[i]) begin
        m_ack[i] = m_g[i] ? 2'b10 : 2'b01;
        m_key[i] = adv(m_base[i], steps[i]);
        m_rr[i] = !m_g[i];
      end else if (m_t[i] == steps[i] + 1) begin
        m_busy[i] = 0; m_ack[i] = 2'b00; m_lfsr[i] = adv(m_base[i], steps[i]);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack%0d", i), 32'(ack_o[i]), 32'(m_ack[i]));
      chk($sformatf("key%0d", i), 32'(key_o[i]), 32'(m_key[i]));
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
      chk($sformatf("lfsr%0d", i), 32'(lfsr_o[i]),
          32'(m_busy[i] ? adv(m_base[i], m_t[i] < steps[i] ? m_t[i] : steps[i]) : m_lfsr[i]));
    end
  endtask
  task automatic wait_ack(input int i, output int n);
    n = 0;
    do begin tick(); n++; end while (ack_o[i] == 2'b00 && n < 100);
    if (n >= 100) chk("ack_timeout", 32'(n), 32'd0);
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (busy_o[i] && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
  endtask
  initial begin
    int n;
    tick();
    reset_i = 2'b00;
    chk("rst_lfsr", 32'(lfsr_o[0]), 32'h0001);
    chk("rst_lfsr_seed0", 32'(lfsr_o[1]), 32'h0001);
    chk("rst_key", 32'(key_o[0]), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    req_i[0] = 2'b01;
    wait_ack(0, n);
    chk("lat16", 32'(n), 32'd17);
    chk("ack_first", 32'(ack_o[0]), 32'h1);
    chk("key_first", 32'(key_o[0]), 32'h0005);
    req_i[0] = 2'b11;
    wait_ack(0, n);
    chk("ack_rr1", 32'(ack_o[0]), 32'h2);
    chk("key_rr1", 32'(key_o[0]), 32'h0011);
    wait_ack(0, n);
    chk("ack_rr0", 32'(ack_o[0]), 32'h1);
    req_i[0] = 2'b00;
    wait_idle(0);
    seed_load_i[0] = 1'b1; seed_value_i[0] = 16'h0000;
    tick();
    seed_load_i[0] = 1'b0;
    chk("seed_zero", 32'(lfsr_o[0]), 32'h0001);
    req_i[0] = 2'b01;
    wait_ack(0, n);
    chk("key_reseed", 32'(key_o[0]), 32'h0005);
    req_i[0] = 2'b00;
    wait_idle(0);
    req_i[0] = 2'b01;
    repeat (4) tick();
    seed_load_i[0] = 1'b1; seed_value_i[0] = 16'h1234; req_i[0] = 2'b00;
    tick();
    seed_load_i[0] = 1'b0;
    wait_ack(0, n);
    chk("ack_dropped", 32'(ack_o[0]), 32'h1);
    chk("key_noseed", 32'(key_o[0]), 32'h0011);
    wait_idle(0);
    req_i[0] = 2'b01;
    repeat (6) tick();
    reset_i[0] = 1'b1; req_i[0] = 2'b00;
    tick();
    reset_i[0] = 1'b0;
    chk("midrst_lfsr", 32'(lfsr_o[0]), 32'h0001);
    chk("midrst_busy", 32'(busy_o[0]), 32'h0);
    chk("midrst_ack", 32'(ack_o[0]), 32'h0);
    req_i[0] = 2'b11;
    wait_ack(0, n);
    chk("midrst_rr", 32'(ack_o[0]), 32'h1);
    chk("midrst_key", 32'(key_o[0]), 32'h0005);
    req_i[0] = 2'b00;
    wait_idle(0);
    seed_load_i[1] = 1'b1; seed_value_i[1] = 16'h8000;
    tick();
    seed_load_i[1] = 1'b0; req_i[1] = 2'b10;
    wait_ack(1, n);
    chk("lat1", 32'(n), 32'd2);
    chk("ack_s1", 32'(ack_o[1]), 32'h2);
    chk("key_s1", 32'(key_o[1]), 32'h0001);
    req_i[1] = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        reset_i[i] = $urandom_range(0, 59) == 0;
        seed_load_i[i] = $urandom_range(0, 7) == 0;
        seed_value_i[i] = $urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom);
        if ($urandom_range(0, 3) == 0) req_i[i] = 2'($urandom);
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lfsr_key_scheduler.md
LFSR_KEY_SCHEDULER -- requirements
Module: lfsr_key_scheduler

Interface
REQ-001 Parameter STEPS, default 16: LFSR advances per delivered key word; legal range 1..255.
REQ-002 Parameter SEED, default 16'h0001: LFSR value after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seed_load  input  1  request to load seed_value into the LFSR; honoured only in IDLE.
REQ-006 seed_value  input  16  new LFSR seed, sampled when seed_load is honoured.
REQ-007 req  input  2  per-channel key-word request; bit n belongs to channel n; level, held until ack[n].
REQ-008 ack  output  2  per-channel one-cycle pulse; key_out is valid in that cycle.
REQ-009 key_out  output  16  registered key word; holds the last delivered word between deliveries.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 lfsr_state  output  16  current internal LFSR register, for debug and verification.

Function
REQ-012 The LFSR shall be 16 bits with polynomial x^16+x^14+1: next = {s[14:0], s[15]^s[13]}.
REQ-013 The LFSR shall advance only in STEP, one shift per clock; it shall hold in all other states.
REQ-014 The FSM shall have the states IDLE, STEP and DELIVER; it enters IDLE on reset.
REQ-015 IDLE with seed_load=1: load seed_value (16'h0000 is replaced by 16'h0001), stay in IDLE, ignore req that cycle.
REQ-016 IDLE with seed_load=0 and req!=0: latch the granted channel, load step counter = STEPS-1, go to STEP.
REQ-017 Arbitration shall be round-robin with pointer rr; a sole requester is always granted; if both request, channel rr is granted.
REQ-018 After each delivery to channel g, rr shall become the other channel (1-g).
REQ-019 STEP: shift the LFSR; if counter==0 go to DELIVER, else decrement the counter.
REQ-020 Entering DELIVER: key_out = the post-shift LFSR value; ack[g] = 1 for exactly that cycle; next state IDLE.
REQ-021 Latency: req seen in IDLE at cycle t gives ack at cycle t+STEPS+1; throughput is one word per STEPS+2 cycles.
REQ-022 At most one ack bit shall be high in any cycle; ack shall never be asserted outside DELIVER.
REQ-023 If the granted req drops during STEP, the word shall still be delivered and acked; it shall not be aborted.
REQ-024 req held high after its ack shall be treated as a new request at the next IDLE arbitration.
REQ-025 seed_load while busy=1 shall be ignored, not queued; lfsr_state is unaffected.
REQ-026 Each delivered word shall be a distinct consecutive slice of the LFSR sequence; no LFSR state is reused between channels.

Reset
REQ-027 Reset shall drive: state=IDLE, lfsr_state=SEED (16'h0001 if SEED==0), key_out=16'h0000, ack=2'b00, busy=0, rr=0, counter=0.
REQ-028 Reset shall take priority over every other input in the same cycle, including mid-STEP and mid-DELIVER; an in-flight word is discarded with no ack.

Verification
REQ-029 Default params, reset, then req=2'b01 held -> busy for 17 cycles, ack=2'b01 at t+17, key_out=16'h0005.
REQ-030 Continue with req=2'b11 held -> next ack=2'b10 with key_out=16'h0011; the following ack is 2'b01 (alternation).
REQ-031 seed_load=1 with seed_value=16'h0000 in IDLE -> lfsr_state=16'h0001 next cycle; a subsequent request yields key_out=16'h0005.
REQ-032 STEPS=1, seed 16'h8000 loaded, req=2'b10 -> ack=2'b10 two cycles after the request, key_out=16'h0001.
REQ-033 seed_load pulsed during STEP -> ignored, key_out matches the unseeded sequence; req dropped mid-STEP -> ack still issued.
REQ-034 reset asserted mid-STEP -> no ack, next cycle lfsr_state=SEED, busy=0, rr=0; a new req=2'b01 yields key_out=16'h0005.
